// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// fifo_wr_arbiter
//   Round-robin write-side arbiter: serialises ALU (2 bytes) and register-file
//   (1 byte) results into the async FIFO write port, honouring FULL.
//   Optional macro: FIFO_ARB_MSB_FIRST_EN (ALU high byte sent first).
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_VLD,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_VLD,
  input  logic                    FULL,
  output logic [DATA_WIDTH-1:0]   WR_DATA,
  output logic                    W_INC,
  output logic                    BUSY,
  output logic                    OVERRUN
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND_RF   = 2'd1,
    SEND_ALU0 = 2'd2,
    SEND_ALU1 = 2'd3
  } state_t;

  localparam logic LAST_ALU = 1'b0;
  localparam logic LAST_RF  = 1'b1;

  state_t                  state_q, state_d;
  logic                    last_q, last_d;
  logic [2*DATA_WIDTH-1:0] alu_buf_q, alu_buf_d;
  logic                    alu_pend_q, alu_pend_d;
  logic [DATA_WIDTH-1:0]   rf_buf_q, rf_buf_d;
  logic                    rf_pend_q, rf_pend_d;
  logic                    overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0]   wr_hold_q, wr_hold_d;

  logic                    w_write;
  logic                    w_rf_done;
  logic                    w_alu_done;
  logic [DATA_WIDTH-1:0]   w_alu_byte0;
  logic [DATA_WIDTH-1:0]   w_alu_byte1;

`ifdef FIFO_ARB_MSB_FIRST_EN
  assign w_alu_byte0 = alu_buf_q[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_alu_byte1 = alu_buf_q[DATA_WIDTH-1:0];
`else
  assign w_alu_byte0 = alu_buf_q[DATA_WIDTH-1:0];
  assign w_alu_byte1 = alu_buf_q[2*DATA_WIDTH-1:DATA_WIDTH];
`endif

  assign w_write    = (state_q != IDLE) & ~FULL;
  assign w_rf_done  = w_write & (state_q == SEND_RF);
  assign w_alu_done = w_write & (state_q == SEND_ALU1);

  assign W_INC   = w_write;
  assign BUSY    = alu_pend_q | rf_pend_q | (state_q != IDLE);
  assign OVERRUN = overrun_q;

  // Capture and overrun: a valid on the final-write edge of its own source
  // reloads the buffer instead of being flagged.
  always_comb begin
    alu_buf_d  = alu_buf_q;
    alu_pend_d = alu_pend_q;
    rf_buf_d   = rf_buf_q;
    rf_pend_d  = rf_pend_q;
    overrun_d  = overrun_q;

    if (w_alu_done) alu_pend_d = 1'b0;
    if (ALU_VLD) begin
      if (!alu_pend_q || w_alu_done) begin
        alu_buf_d  = ALU_OUT;
        alu_pend_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (w_rf_done) rf_pend_d = 1'b0;
    if (RF_RD_VLD) begin
      if (!rf_pend_q || w_rf_done) begin
        rf_buf_d  = RF_RD_DATA;
        rf_pend_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rf_pend_q && (!alu_pend_q || (last_q == LAST_ALU))) begin
          state_d = SEND_RF;
        end else if (alu_pend_q) begin
          state_d = SEND_ALU0;
        end
      end
      SEND_RF: begin
        if (w_write) begin
          if (alu_pend_q)     state_d = SEND_ALU0;
          else if (RF_RD_VLD) state_d = SEND_RF;
          else                state_d = IDLE;
        end
      end
      SEND_ALU0: begin
        if (w_write) state_d = SEND_ALU1;
      end
      SEND_ALU1: begin
        if (w_write) begin
          if (rf_pend_q)    state_d = SEND_RF;
          else if (ALU_VLD) state_d = SEND_ALU0;
          else              state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (state_d == SEND_RF)   last_d = LAST_RF;
    if (state_d == SEND_ALU0) last_d = LAST_ALU;
  end

  // Output byte is held in IDLE so the FIFO data lines do not toggle.
  always_comb begin
    wr_hold_d = wr_hold_q;
    unique case (state_q)
      SEND_RF:   wr_hold_d = rf_buf_q;
      SEND_ALU0: wr_hold_d = w_alu_byte0;
      SEND_ALU1: wr_hold_d = w_alu_byte1;
      default:   wr_hold_d = wr_hold_q;
    endcase
  end

  assign WR_DATA = wr_hold_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      last_q     <= LAST_ALU;
      alu_buf_q  <= '0;
      alu_pend_q <= 1'b0;
      rf_buf_q   <= '0;
      rf_pend_q  <= 1'b0;
      overrun_q  <= 1'b0;
      wr_hold_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      alu_buf_q  <= alu_buf_d;
      alu_pend_q <= alu_pend_d;
      rf_buf_q   <= rf_buf_d;
      rf_pend_q  <= rf_pend_d;
      overrun_q  <= overrun_d;
      wr_hold_q  <= wr_hold_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected bytes queued by stimulus,
// popped by a monitor on every FIFO write.
`default_nettype none

module tb_fifo_wr_arbiter;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [2*DW-1:0] ALU_OUT = '0;
  logic          ALU_VLD = 1'b0;
  logic [DW-1:0] RF_RD_DATA = '0;
  logic          RF_RD_VLD = 1'b0;
  logic          FULL = 1'b0;
  logic [DW-1:0] WR_DATA;
  logic          W_INC;
  logic          BUSY;
  logic          OVERRUN;

  fifo_wr_arbiter #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .ALU_VLD(ALU_VLD),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_VLD(RF_RD_VLD), .FULL(FULL),
    .WR_DATA(WR_DATA), .W_INC(W_INC), .BUSY(BUSY), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DW-1:0] exp_q[$];
  int wr_cyc[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: W_INC seen at negedge means a write at the coming posedge.
  always @(negedge CLK) begin
    if (RST && W_INC) begin
      wr_cyc.push_back(cyc);
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_write: got WR_DATA=0x%02h, expected no write", WR_DATA);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (WR_DATA !== e) begin
          errors = errors + 1;
          $display("FAIL wr_data: got 0x%02h, expected 0x%02h", WR_DATA, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_alu(input logic [2*DW-1:0] v);
`ifdef FIFO_ARB_MSB_FIRST_EN
    exp_q.push_back(v[2*DW-1:DW]);
    exp_q.push_back(v[DW-1:0]);
`else
    exp_q.push_back(v[DW-1:0]);
    exp_q.push_back(v[2*DW-1:DW]);
`endif
  endtask

  task automatic pulse_alu(input logic [2*DW-1:0] v);
    ALU_OUT = v; ALU_VLD = 1'b1;
    @(posedge CLK); #1;
    ALU_VLD = 1'b0;
  endtask

  task automatic pulse_rf(input logic [DW-1:0] v);
    RF_RD_DATA = v; RF_RD_VLD = 1'b1;
    @(posedge CLK); #1;
    RF_RD_VLD = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK); #1;
      if (!BUSY && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    checks = checks + 1;
    if (!done) begin
      errors = errors + 1;
      $display("FAIL %s_timeout: got BUSY=%0b pending=%0d, expected idle", name, BUSY, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int n0;
    logic [DW-1:0] stall_byte;

    repeat (2) @(posedge CLK);
    #1;
    check("rst_w_inc", W_INC, 0);
    check("rst_busy", BUSY, 0);
    check("rst_overrun", OVERRUN, 0);
    check("rst_wr_data", WR_DATA, 0);
    RST = 1'b1;
    @(posedge CLK); #1;

    // Single RF byte
    n0 = wr_cyc.size();
    exp_q.push_back(8'hA5);
    pulse_rf(8'hA5);
    wait_idle("rf_single");
    check("rf_write_count", wr_cyc.size() - n0, 1);
    check("rf_busy_after", BUSY, 0);

    // ALU two bytes on consecutive edges
    n0 = wr_cyc.size();
    push_alu(16'h1234);
    pulse_alu(16'h1234);
    wait_idle("alu_single");
    check("alu_write_count", wr_cyc.size() - n0, 2);
    if (wr_cyc.size() - n0 == 2) check("alu_consecutive", wr_cyc[n0+1] - wr_cyc[n0], 1);

    // Simultaneous: RF wins (ALU last served), three back-to-back writes
    n0 = wr_cyc.size();
    exp_q.push_back(8'h5A);
    push_alu(16'hBEEF);
    ALU_OUT = 16'hBEEF; ALU_VLD = 1'b1;
    RF_RD_DATA = 8'h5A; RF_RD_VLD = 1'b1;
    @(posedge CLK); #1;
    ALU_VLD = 1'b0; RF_RD_VLD = 1'b0;
    wait_idle("simul");
    check("simul_write_count", wr_cyc.size() - n0, 3);
    if (wr_cyc.size() - n0 == 3) check("simul_no_bubble", wr_cyc[n0+2] - wr_cyc[n0], 2);

    // FULL stall of 5 cycles in SEND_ALU0
    push_alu(16'hCAFE);
`ifdef FIFO_ARB_MSB_FIRST_EN
    stall_byte = 8'hCA;
`else
    stall_byte = 8'hFE;
`endif
    pulse_alu(16'hCAFE);
    @(posedge CLK); #1;
    FULL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("stall_w_inc", W_INC, 0);
      check("stall_wr_data", WR_DATA, stall_byte);
    end
    @(posedge CLK); #1;
    FULL = 1'b0;
    wait_idle("stall");
    check("no_overrun_yet", OVERRUN, 0);

    // Overrun during stall, then reload on final-write edge
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h3C);
    pulse_rf(8'h11);
    @(posedge CLK); #1;
    FULL = 1'b1;
    pulse_rf(8'h77);
    check("overrun_set", OVERRUN, 1);
    @(posedge CLK); #1;
    RF_RD_DATA = 8'h3C; RF_RD_VLD = 1'b1; FULL = 1'b0;
    @(posedge CLK); #1;
    RF_RD_VLD = 1'b0;
    wait_idle("overrun");
    check("overrun_sticky", OVERRUN, 1);

    // Reset in the middle of SEND_ALU1
    push_alu(16'h9876);
    void'(exp_q.pop_back());
    pulse_alu(16'h9876);
    @(posedge CLK);
    @(posedge CLK); #2;
    check("pre_rst_w_inc", W_INC, 1);
    RST = 1'b0;
    #1;
    check("mid_rst_w_inc", W_INC, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_overrun", OVERRUN, 0);
    check("mid_rst_wr_data", WR_DATA, 0);
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("post_rst_busy", BUSY, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side sequencer and arbiter for the system's asynchronous FIFO, running in the FIFO write-clock domain. It shares the single FIFO write port between two one-cycle-pulsed producers: the ALU (16-bit result, written as two bytes) and the register file (8-bit read data). It captures each result, arbitrates round-robin on contention and serialises the bytes into the FIFO, honouring FULL. It also flags any result that arrives while the previous one from the same source is still undelivered.

## Interface
- DATA_WIDTH, 8, FIFO word width; ALU result width is 2*DATA_WIDTH.
- CLK  in  1  FIFO write clock (same net as FIFO W_CLK).
- RST  in  1  asynchronous, active-low reset.
- ALU_OUT  in  2*DATA_WIDTH  ALU result, valid with ALU_VLD.
- ALU_VLD  in  1  one-cycle pulse: capture ALU_OUT.
- RF_RD_DATA  in  DATA_WIDTH  register-file read data, valid with RF_RD_VLD.
- RF_RD_VLD  in  1  one-cycle pulse: capture RF_RD_DATA.
- FULL  in  1  FIFO full flag, already synchronised to CLK.
- WR_DATA  out  DATA_WIDTH  byte to FIFO; 0 at reset.
- W_INC  out  1  FIFO write enable; 0 at reset.
- BUSY  out  1  any capture pending or FSM not IDLE; 0 at reset.
- OVERRUN  out  1  sticky error flag; 0 at reset.

## Operation
- Capture registers: alu_buf (2*DATA_WIDTH) with alu_pend, and rf_buf (DATA_WIDTH) with rf_pend.
  - A valid pulse loads the buffer and sets its pend flag.
- FSM states: IDLE, SEND_RF, SEND_ALU0, SEND_ALU1.
  - IDLE goes to the SEND state of a pending source.
  - SEND_RF exits on write.
  - SEND_ALU0 goes to SEND_ALU1 on write; SEND_ALU1 exits on write.
- A write happens at a CLK edge where W_INC=1. W_INC = (state != IDLE) & ~FULL, combinational.
- WR_DATA is muxed from the buffer by state. It holds its value in IDLE and during FULL stalls.
- Exit from a final byte (SEND_RF or SEND_ALU1):
  - If the other source is pending, go directly to its SEND state (no bubble).
  - Else, if the same source is pending again, go to its SEND state.
  - Else go to IDLE.
- Arbitration is round-robin via a last_served bit (reset value = ALU, so RF wins the first tie).
  - With both pending at a decision point, the source not last served wins.
  - last_served updates at entry to a SEND state.
- A pend flag clears on the edge that writes that source's final byte, unless a new valid for that source arrives on the same edge. In that case the buffer reloads and pend stays 1, with no overrun.
- Overrun: a valid arriving while its pend=1, other than on that final-write edge.
  - The new data is dropped and the buffer is unchanged.
  - OVERRUN sets and stays 1 until RST.
- Simultaneous ALU_VLD and RF_RD_VLD: both are captured and arbitration applies.
- FULL asserted in a SEND state: the FSM holds state, W_INC=0 and WR_DATA is stable. Unlimited stalls are allowed.
- RST low at any time: all registers and outputs clear immediately, W_INC=0 asynchronously, and any in-flight transfer is discarded.

## Timing
- Valid sampled at edge E0; pend=1 after E0.
- FSM enters SEND at E1.
- With FULL=0, W_INC is high between E1 and E2 and the first byte is written at E2.
- The second ALU byte is written at E3.
- Throughput: one byte per cycle while FULL=0, including across source switches.
- FULL affects W_INC in the same cycle (combinational). A stalled write completes at the first edge with FULL=0.

## Configuration
- FIFO_ARB_MSB_FIRST_EN
  - Defined: SEND_ALU0 carries ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH] and SEND_ALU1 carries the low byte.
  - Undefined (default): low byte first, then high byte.
  - Latency and arbitration are unchanged either way.

## Test plan
- Reset with RST=0 mid-SEND_ALU1 and FULL=0 → W_INC drops immediately; BUSY=0, OVERRUN=0, WR_DATA=0 after reset.
- RF_RD_VLD with 0xA5, FULL=0 → W_INC=1 exactly one cycle, WR_DATA=0xA5 written at E2, BUSY returns to 0.
- ALU_VLD with 0x1234, macro undefined → writes 0x34 then 0x12 on consecutive edges. With FIFO_ARB_MSB_FIRST_EN defined → 0x12 then 0x34.
- ALU_VLD=0xBEEF and RF_RD_VLD=0x5A on the same edge after reset → order 0x5A, 0xEF, 0xBE with three consecutive W_INC cycles.
- FULL held high for 5 cycles during SEND_ALU0 → W_INC=0 and WR_DATA stable throughout; both bytes are written after FULL falls, no data lost.
- Second RF_RD_VLD (0x77) during a FULL stall of the first → OVERRUN=1 sticky, 0x77 never written. A further RF_RD_VLD pulsed on the final-write edge → accepted and written next, OVERRUN not newly triggered.
